// File: rtl/fir_mse_monitor_if.sv
// Sample/result bundle between the FIR pair and the error monitor.
// Ports (slave view): valid_in, y_ref, y_dut in; mse, max_err, mse_valid, win_count out.
interface fir_mse_monitor_if #(
  parameter int unsigned WIDTH = 16
);
  logic                   valid_in;
  logic [WIDTH-1:0]       y_ref;
  logic [WIDTH-1:0]       y_dut;
  logic [2*WIDTH-1:0]     mse;
  logic [WIDTH-1:0]       max_err;
  logic                   mse_valid;
  logic [15:0]            win_count;

  // Source side: drives the sample pair, observes the results.
  modport master (
    output valid_in, y_ref, y_dut,
    input  mse, max_err, mse_valid, win_count
  );

  // Monitor side.
  modport slave (
    input  valid_in, y_ref, y_dut,
    output mse, max_err, mse_valid, win_count
  );
endinterface

// File: rtl/fir_mse_monitor.sv
// Windowed MSE / peak-absolute-error monitor comparing an approximate FIR output
// against the exact reference FIR output over windows of 2^LOG2_WIN samples.
// Ports: clk, rst (sync, active-high), bus (slave modport of fir_mse_monitor_if):
//   valid_in/y_ref/y_dut in; mse/max_err/mse_valid/win_count out.
module fir_mse_monitor #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned LOG2_WIN = 8
) (
  input  logic               clk,
  input  logic               rst,
  fir_mse_monitor_if.slave   bus
);

  localparam int unsigned DW = WIDTH + 1;
  localparam int unsigned SW = 2 * WIDTH;
  localparam int unsigned AW = SW + LOG2_WIN;

  // Stage 1: signed difference at WIDTH+1 bits, then magnitude.
  logic signed [DW-1:0] diff_c;
  logic        [DW-1:0] mag_c;

  always_comb begin
    diff_c = $signed({bus.y_dut[WIDTH-1], bus.y_dut}) - $signed({bus.y_ref[WIDTH-1], bus.y_ref});
    mag_c  = diff_c[DW-1] ? DW'(-diff_c) : DW'(diff_c);
  end

  logic             v1;
  logic [WIDTH-1:0] absd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      absd1 <= '0;
    end else begin
      v1 <= bus.valid_in;
      // |diff| never exceeds 2^WIDTH-1, so the top bit is always zero here.
      if (bus.valid_in) absd1 <= mag_c[WIDTH-1:0];
    end
  end

  // Stage 2: square, carrying the magnitude alongside for the peak tracker.
  logic             v2;
  logic [SW-1:0]    sq2;
  logic [WIDTH-1:0] absd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2    <= 1'b0;
      sq2   <= '0;
      absd2 <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        sq2   <= SW'(absd1) * SW'(absd1);
        absd2 <= absd1;
      end
    end
  end

  // Stage 3: accumulate and close windows.
  logic [AW-1:0]       acc;
  logic [WIDTH-1:0]    run_max;
  logic [LOG2_WIN-1:0] cnt;

  logic [AW-1:0]       sum_c;
  logic [WIDTH-1:0]    max_c;
  logic                close_c;

  always_comb begin
    sum_c   = acc + AW'(sq2);
    max_c   = (absd2 > run_max) ? absd2 : run_max;
    close_c = v2 && (cnt == {LOG2_WIN{1'b1}});
  end

  logic [SW-1:0]    mse_q;
  logic [WIDTH-1:0] max_err_q;
  logic             mse_valid_q;
  logic [15:0]      win_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      run_max     <= '0;
      cnt         <= '0;
      mse_q       <= '0;
      max_err_q   <= '0;
      mse_valid_q <= 1'b0;
      win_count_q <= '0;
    end else begin
      mse_valid_q <= 1'b0;
      if (close_c) begin
        // Window sum is bounded by 2^LOG2_WIN*(2^WIDTH-1)^2, so the quotient fits in 2*WIDTH.
        mse_q       <= SW'(sum_c >> LOG2_WIN);
        max_err_q   <= max_c;
        mse_valid_q <= 1'b1;
        acc         <= '0;
        run_max     <= '0;
        cnt         <= '0;
        if (win_count_q != 16'hFFFF) win_count_q <= win_count_q + 16'd1;
      end else if (v2) begin
        acc     <= sum_c;
        run_max <= max_c;
        cnt     <= cnt + LOG2_WIN'(1);
      end
    end
  end

  assign bus.mse       = mse_q;
  assign bus.max_err   = max_err_q;
  assign bus.mse_valid = mse_valid_q;
  assign bus.win_count = win_count_q;

endmodule

// File: doc/fir_mse_monitor.md
# fir_mse_monitor

Streaming error monitor that sits directly downstream of the FIR filter in the ECG approximate-arithmetic evaluation flow. It consumes the output of the approximate FIR under test and, in lockstep, the output of the exact reference FIR. Over fixed windows of 2^LOG2_WIN samples it computes the mean squared error and the peak absolute error. Results are produced in hardware, so MSE figures per adder variant come straight from simulation or silicon without post-processing the output text files.

## Interface
- WIDTH, 16: sample width of both FIR outputs, signed two's complement.
- LOG2_WIN, 8: log2 of the window length; legal range 1..16.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  y_ref/y_dut pair valid this cycle; no backpressure, every valid pair is accepted.
- y_ref  in  WIDTH  exact FIR output sample, signed.
- y_dut  in  WIDTH  approximate FIR output sample, signed.
- mse  out  2*WIDTH  window MSE, unsigned, truncated.
- max_err  out  WIDTH  window peak |y_dut - y_ref|, unsigned.
- mse_valid  out  1  one-cycle pulse; mse/max_err updated and valid.
- win_count  out  16  completed windows since reset, saturates at 0xFFFF.

## Operation
- Stage 1, on valid_in:
  - diff = y_dut - y_ref, computed at WIDTH+1 bits signed with no overflow.
  - absd = |diff|, WIDTH bits unsigned, maximum 2^WIDTH-1.
- Stage 2:
  - sq = absd*absd, 2*WIDTH bits unsigned; cannot overflow.
  - Stage valid bits v1 and v2 follow valid_in down the pipeline.
- Stage 3 (accumulate), when v2:
  - acc (2*WIDTH+LOG2_WIN bits) <= acc + sq.
  - run_max <= max(run_max, absd2), where absd2 is absd carried alongside sq.
  - cnt (LOG2_WIN bits) increments and wraps.
- Window close: a v2 with cnt == 2^LOG2_WIN-1 closes the window.
  - mse <= (acc + sq) >> LOG2_WIN (floor).
  - max_err <= max(run_max, absd2).
  - mse_valid <= 1.
  - acc, run_max and cnt <= 0.
  - win_count increments unless it is already 0xFFFF.
- Windows are back-to-back. The first sample of the next window can reach stage 3 the cycle after a close with no loss, because acc was cleared at the close edge.
- Gaps in valid_in are allowed anywhere; bubbles propagate through v1/v2 and never count as samples.
- mse and max_err hold their value until the next close.

## Timing
- Latency: a pair accepted at edge E0 is accumulated at edge E2.
  - If it is the last sample of a window, mse_valid is high during the cycle after E2 (between E2 and E3).
- mse_valid is high for exactly one cycle per window.
- Throughput: one pair per clock, sustained.
- Reset values (all outputs and state, on any clk edge with rst=1):
  - mse=0, max_err=0, mse_valid=0, win_count=0.
  - acc=0, run_max=0, cnt=0, v1=v2=0.
- rst mid-window: the partial window is discarded and in-flight pipeline samples are dropped. The first valid_in after rst deasserts starts a fresh window.
- valid_in while rst=1 is ignored.
- Extremes: y_ref=+2^(WIDTH-1)-1 with y_dut=-2^(WIDTH-1) gives absd=2^WIDTH-1. acc must not overflow for a full window of such samples.

## Test plan
- LOG2_WIN=2, four pairs with y_dut=y_ref (values 100,-5,0,32767) -> mse_valid pulse with mse=0, max_err=0, win_count=1.
- LOG2_WIN=2, diffs +3,-3,+3,-3 -> mse=9, max_err=3.
- LOG2_WIN=2, diffs 1,2,3,4 -> sum 30, mse=7 (truncated), max_err=4.
- LOG2_WIN=2, four pairs y_ref=32767, y_dut=-32768 -> mse=4294836225, max_err=65535, no wrap.
- LOG2_WIN=2, diffs 2,2,2,2 with random gaps in valid_in, followed immediately by a second window of diffs 1,1,1,1 at full rate:
  - mse=4, then mse=1.
  - Each pulse comes exactly 2 edges after its last accepted pair.
  - win_count=2.
- LOG2_WIN=2, two pairs of diff 10, then rst for 1 cycle, then four pairs of diff 1:
  - No pulse before rst; all outputs return to 0 during rst.
  - The next pulse has mse=1, max_err=1, win_count=1.
